// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one Uart8 transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     err,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   txEn,
    output logic                   txStart,
    output logic [7:0]             txIn,
    input  logic                   txBusy,
    input  logic                   txDone
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_in_q, tx_in_d;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [7:0]         win_byte;
    int                 idx;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        win_byte = 8'h00;
        idx      = 0;
        // Scan starts just past the last winner so a held request cannot win twice in a row.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_idx     = PTR_W'(idx);
                win_oh[idx] = 1'b1;
                win_byte    = data[8*idx +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        grant_d    = grant_q;
        tx_start_d = tx_start_q;
        tx_in_d    = tx_in_q;
        ack_d      = '0;
        err_d      = '0;
        case (state_q)
            S_IDLE: begin
                grant_d    = '0;
                tx_start_d = 1'b0;
                if (en && found) begin
                    grant_d    = win_oh;
                    tx_in_d    = win_byte;
                    tx_start_d = 1'b1;
                    ptr_d      = win_idx;
                    timer_d    = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                // txDone is deliberately not looked at here: it may be left over from the previous byte.
                if (!en || (!txBusy && timer_q == TMR_W'(START_TIMEOUT - 1))) begin
                    tx_start_d = 1'b0;
                    err_d      = grant_q;
                    grant_d    = '0;
                    state_d    = S_IDLE;
                end else if (txBusy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_SEND;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_SEND: begin
                if (!en) begin
                    tx_start_d = 1'b0;
                    err_d      = grant_q;
                    grant_d    = '0;
                    state_d    = S_IDLE;
                end else if (txDone && !txBusy) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                grant_d    = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            timer_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            tx_start_q <= 1'b0;
            tx_in_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_in_q    <= tx_in_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign txEn    = en;
    assign txStart = tx_start_q;
    assign txIn    = tx_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed-vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [3:0]  grant;
    logic        busy;
    logic        txEn;
    logic        txStart;
    logic [7:0]  txIn;
    logic        txBusy;
    logic        txDone;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .START_TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .err     (err),
        .grant   (grant),
        .busy    (busy),
        .txEn    (txEn),
        .txStart (txStart),
        .txIn    (txIn),
        .txBusy  (txBusy),
        .txDone  (txDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int idx, input logic [7:0] b, input int hold, input logic [3:0] req_mid);
        @(negedge clk);
        chk("grant_start", 32'(txStart), 32'd1);
        chk("grant_onehot", 32'(grant), 32'd1 << idx);
        chk("grant_txin", 32'(txIn), 32'(b));
        chk("grant_busy", 32'(busy), 32'd1);
        req = req_mid;
        repeat (hold) begin
            @(negedge clk);
            chk("start_hold", 32'(txStart), 32'd1);
        end
        txBusy = 1'b1;
        @(negedge clk);
        chk("start_drop", 32'(txStart), 32'd0);
        chk("send_grant", 32'(grant), 32'd1 << idx);
        @(negedge clk);
        chk("send_no_ack", 32'(ack), 32'd0);
        txBusy = 1'b0;
        txDone = 1'b1;
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 32'd1 << idx);
        chk("ack_grant_clr", 32'(grant), 32'd0);
        chk("ack_no_err", 32'(err), 32'd0);
        txDone = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        req    = 4'b0000;
        data   = 32'h44332211;
        txBusy = 1'b0;
        txDone = 1'b0;

        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(txStart), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txin", 32'(txIn), 32'd0);
        chk("rst_ack_err", 32'({ack, err}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_grant", 32'(grant), 32'd0);
        chk("txen_low", 32'(txEn), 32'd0);

        // Contention: round robin from requester 0 after reset
        en  = 1'b1;
        req = 4'b1111;
        xfer(0, 8'h11, 0, 4'b1111);
        xfer(1, 8'h22, 0, 4'b1111);
        xfer(2, 8'h33, 0, 4'b1111);
        xfer(3, 8'h44, 0, 4'b1111);
        xfer(0, 8'h11, 0, 4'b1111);
        req = 4'b0000;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("idle_after_ack", 32'(busy), 32'd0);

        // Single requester with a slow txBusy response
        data[7:0] = 8'h8A;
        req       = 4'b0001;
        xfer(0, 8'h8A, 3, 4'b0001);
        req = 4'b0000;
        @(negedge clk);
        chk("single_ack_clr", 32'(ack), 32'd0);
        chk("single_idle", 32'(grant), 32'd0);

        // Late arrival: req0 held, req2 rises mid-byte
        data[7:0]   = 8'h5A;
        data[23:16] = 8'hC3;
        req         = 4'b0001;
        xfer(0, 8'h5A, 0, 4'b0101);
        xfer(2, 8'hC3, 0, 4'b0101);
        xfer(0, 8'h5A, 0, 4'b0001);
        req = 4'b0000;
        @(negedge clk);

        // Timeout: txBusy never rises, requester 1 wins from ptr 0
        req = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to_start_high", 32'(txStart), 32'd1);
        end
        chk("to_owner", 32'(grant), 32'b0010);
        @(negedge clk);
        chk("to_err", 32'(err), 32'b0010);
        chk("to_start_low", 32'(txStart), 32'd0);
        chk("to_grant_clr", 32'(grant), 32'd0);
        chk("to_no_ack", 32'(ack), 32'd0);
        req = 4'b0001;
        @(negedge clk);
        chk("to_next_grant", 32'(grant), 32'b0001);
        chk("to_next_txin", 32'(txIn), 32'h5A);

        // en drop during SEND, coinciding with txDone: en wins
        txBusy = 1'b1;
        @(negedge clk);
        chk("en_send_start", 32'(txStart), 32'd0);
        en     = 1'b0;
        txDone = 1'b1;
        @(negedge clk);
        chk("en_err", 32'(err), 32'b0001);
        chk("en_no_ack", 32'(ack), 32'd0);
        chk("en_grant_clr", 32'(grant), 32'd0);
        chk("en_start_low", 32'(txStart), 32'd0);
        txBusy = 1'b0;
        txDone = 1'b0;
        req    = 4'b1111;
        data   = 32'h44332211;
        @(negedge clk);
        chk("en_low_no_grant", 32'(grant), 32'd0);
        chk("en_low_idle", 32'(busy), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("reen_grant", 32'(grant), 32'b0010);
        chk("reen_txin", 32'(txIn), 32'h22);
        chk("reen_txen", 32'(txEn), 32'd1);

        // Async reset mid-START
        #2;
        reset = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_start", 32'(txStart), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_txin", 32'(txIn), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'b0001);
        chk("post_rst_txin", 32'(txIn), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one Uart8 transmitter among NUM_REQ byte producers.
- Latches the winning requester's byte and drives txStart/txIn with the Uart8 start handshake: hold start until busy, then wait for done.
- Returns a one-cycle ack to the winner.
- Sits between client blocks (command responders, loggers) and the Uart8 tx interface. One clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 4096, clocks to wait for txBusy after raising txStart before aborting (must exceed one baud period plus Uart8 sync latency)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  arbiter enable; drives Uart8 txEn
req  input  NUM_REQ  per-requester send request, level; held until ack or err
data  input  8*NUM_REQ  requester bytes; requester i on bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse to the requester whose byte completed (txDone seen)
err  output  NUM_REQ  one-cycle pulse to the requester whose transfer aborted (timeout or en drop)
grant  output  NUM_REQ  one-hot current owner; zero in IDLE
busy  output  1  high in any state other than IDLE
txEn  output  1  to Uart8 txEn (= en)
txStart  output  1  to Uart8 txStart
txIn  output  8  to Uart8 txIn; latched byte
txBusy  input  1  from Uart8 txBusy
txDone  input  1  from Uart8 txDone

Behaviour:
- Reset (async): state IDLE; ack, err, grant = 0; txStart = 0; busy = 0; txIn = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
- Outputs are registered. txEn is combinational from en.
- States:
  - IDLE: if en and any req, pick the first set req scanning from (ptr+1) mod NUM_REQ upward with wrap. Next cycle: grant one-hot, txIn = that byte, txStart = 1, ptr = winner, timer = 0, go START.
  - START: txStart held 1.
    - txBusy==1 -> txStart=0, go SEND.
    - timer reaches START_TIMEOUT-1 -> txStart=0, err pulse to owner, go IDLE.
  - SEND: txStart 0. On txDone==1 with txBusy==0 -> ack pulse to owner, grant=0, go IDLE.
- Stale txDone from a previous byte is ignored: START never samples txDone.
- Latency: req to txStart high = 1 clock. Transfer end (txDone) to ack = 1 clock. Back-to-back grants: next winner gets txStart in the clock after ack. There is one IDLE cycle between bytes.
- Fairness: a requester holding req continuously cannot win twice while another req is pending.
- Data and req after grant:
  - data is sampled only at grant. Later changes to data or req do not affect the byte in flight.
  - Dropping req mid-transfer does not abort; ack still pulses.
- en low in any non-IDLE state: next clock txStart=0, err pulse to owner, grant=0, go IDLE. en low in IDLE: no grant.
- A single req with no contention is granted in the clock after IDLE is re-entered.
- ack and err are never both asserted; at most one bit of each is high.
- reset mid-transfer: immediate return to reset values. Uart8 shares the same reset.
- Simultaneous en fall and txBusy/txDone in the same cycle: en takes priority (err, not ack).

Test Plan:
- Single requester: en=1, req=4'b0001, data0=8'h8A -> txStart 1 clock later, txIn=8'h8A. txStart drops the clock after txBusy=1. Exactly one ack[0] pulse the clock after txDone. Downstream Uart8 rx captures 8'b10001010.
- Contention: req=4'b1111 held, bytes 8'h11,22,33,44 -> grants in order 0,1,2,3,0. Each ack pulses once per byte. No back-to-back grants to the same index.
- Late-arriving requester: req0 held continuously; req2 rises during byte 1 -> byte 2 goes to requester 2, not 0.
- Timeout: stub txBusy tied 0 with START_TIMEOUT=16 -> txStart high for 16 clocks, err[owner] pulse, returns to IDLE. Next pending requester is granted.
- en drop: deassert en during SEND -> err pulse to owner, txStart=0, grant=0 next clock, no ack. Re-enabling en restarts arbitration from ptr+1.
- Async reset asserted mid-START -> all outputs zero immediately. After release, requester 0 wins first when all requests are set.
